// File: rtl/inert_chan_rdr.sv
// rtl/inert_chan_rdr.sv - inertial sensor channel reader over an SPI master; INERT_OVR_DETECT_EN enables the overrun flag
module inert_chan_rdr #(
    parameter int          NUM_CH      = 2,
    parameter logic [63:0] CH_ADDR     = 64'h0000_0000_0000_2C22,
    parameter int          STARTUP_CYC = 61455,
    parameter int          INIT_GAP    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  INT,
    output logic                  wrt,
    output logic [15:0]           cmd,
    input  logic                  done,
    input  logic [15:0]           rd_data,
    output logic [16*NUM_CH-1:0]  samples,
    output logic                  vld,
    output logic                  busy,
    output logic                  ovr,
    input  logic                  clr_ovr
);

    localparam logic [3:0]  LAST_RD     = 4'(2 * NUM_CH - 1);
    localparam logic [31:0] STARTUP_END = 32'(STARTUP_CYC - 1);
    localparam logic [31:0] GAP_END     = 32'(INIT_GAP - 1);

    typedef enum logic [2:0] {
        STARTUP, INIT_CMD, INIT_WAIT, WAIT_INT, RD, UPDATE
    } state_t;

    state_t                 state, state_n;
    logic [31:0]            cnt, cnt_n;
    logic [1:0]             init_idx, init_idx_n;
    logic [3:0]             rd_idx, rd_idx_n;
    logic                   wrt_n, vld_n;
    logic [15:0]            cmd_n;
    logic [16*NUM_CH-1:0]   stage, stage_n, samples_n;
    logic                   int_m, int_s;

    // Fixed sensor configuration words, written once after power-up
    function automatic logic [15:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 16'h0D02;
            2'd1:    return 16'h1053;
            2'd2:    return 16'h1150;
            default: return 16'h1460;
        endcase
    endfunction

    // Read k: channel k/2, low byte at addr, high byte at addr+1
    function automatic logic [15:0] rd_cmd(input logic [3:0] k);
        logic [7:0] a;
        a = 8'h00;
        for (int c = 0; c < 8; c++) begin
            if (k[3:1] == c[2:0]) a = CH_ADDR[8*c +: 8];
        end
        a = a + {7'b0, k[0]};
        return {1'b1, a[6:0], 8'h00};
    endfunction

    // Two-flop synchronizer for the asynchronous data-ready line
    always_ff @(posedge clk) begin
        if (rst) begin
            int_m <= 1'b0;
            int_s <= 1'b0;
        end else begin
            int_m <= INT;
            int_s <= int_m;
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        init_idx_n = init_idx;
        rd_idx_n   = rd_idx;
        wrt_n      = 1'b0;
        cmd_n      = cmd;
        vld_n      = 1'b0;
        samples_n  = samples;
        stage_n    = stage;
        case (state)
            STARTUP: begin
                if (cnt == STARTUP_END) begin
                    wrt_n      = 1'b1;
                    cmd_n      = init_cmd(2'd0);
                    init_idx_n = 2'd0;
                    state_n    = INIT_WAIT;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            INIT_CMD: begin
                if (cnt == GAP_END) begin
                    wrt_n   = 1'b1;
                    cmd_n   = init_cmd(init_idx);
                    state_n = INIT_WAIT;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            INIT_WAIT: begin
                if (done) begin
                    if (init_idx == 2'd3) begin
                        state_n = WAIT_INT;
                    end else begin
                        init_idx_n = init_idx + 2'd1;
                        cnt_n      = 32'd0;
                        state_n    = INIT_CMD;
                    end
                end
            end
            WAIT_INT: begin
                if (int_s) begin
                    wrt_n    = 1'b1;
                    cmd_n    = rd_cmd(4'd0);
                    rd_idx_n = 4'd0;
                    state_n  = RD;
                end
            end
            RD: begin
                if (done) begin
                    for (int i = 0; i < 2 * NUM_CH; i++) begin
                        if (rd_idx == 4'(i)) stage_n[8*i +: 8] = rd_data[7:0];
                    end
                    if (rd_idx == LAST_RD) begin
                        state_n = UPDATE;
                    end else begin
                        rd_idx_n = rd_idx + 4'd1;
                        wrt_n    = 1'b1;
                        cmd_n    = rd_cmd(rd_idx + 4'd1);
                    end
                end
            end
            UPDATE: begin
                samples_n = stage;
                vld_n     = 1'b1;
                state_n   = WAIT_INT;
            end
            default: state_n = STARTUP;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STARTUP;
            cnt      <= 32'd0;
            init_idx <= 2'd0;
            rd_idx   <= 4'd0;
            wrt      <= 1'b0;
            cmd      <= 16'h0000;
            vld      <= 1'b0;
            samples  <= '0;
            stage    <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            init_idx <= init_idx_n;
            rd_idx   <= rd_idx_n;
            wrt      <= wrt_n;
            cmd      <= cmd_n;
            vld      <= vld_n;
            samples  <= samples_n;
            stage    <= stage_n;
        end
    end

    assign busy = (state != WAIT_INT);

    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:8];

`ifdef INERT_OVR_DETECT_EN
    logic int_d;

    // A fresh data-ready edge while a set is still being read means a sample was lost
    always_ff @(posedge clk) begin
        if (rst) begin
            int_d <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            int_d <= int_s;
            if (int_s && !int_d && (state == RD || state == UPDATE)) ovr <= 1'b1;
            else if (clr_ovr) ovr <= 1'b0;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_ovr;
    assign ovr        = 1'b0;
`endif

endmodule
